// File: rtl/xps2_host_bridge_pkg.sv
// Shared constants, state encodings and key-word layout for the PS/2 host bridge.
package xps2_host_bridge_pkg;

  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
  localparam logic [7:0] PS2_BRK_CODE = 8'hF0;
  localparam int         BRK_BIT      = 8;
  localparam int         EXT_BIT      = 9;
  localparam int         KEY_W        = 10;
  localparam int         FRAME_BITS   = 11;

  typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;

  typedef enum logic [2:0] {
    H_IDLE, H_POLL0, H_POLL1, H_WRKEY, H_WRFLAG
  } host_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_word_t;

  // Frame is {stop, parity, d7..d0, start}; odd parity covers d0..d7 plus parity.
  function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
    return !f[0] && f[10] && (^f[9:1]);
  endfunction

endpackage

// File: rtl/xps2_rx.sv
// PS/2 frame receiver: input synchronizers, falling-edge detect, 11-bit shift,
// parity/framing check and inter-edge timeout.
module xps2_rx
  import xps2_host_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_vld,
  output logic       rx_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]            clk_sync, dat_sync;
  logic                  clk_q;
  logic                  fall;
  logic                  timeout;
  rx_state_t             state, state_nxt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg, frame_nxt;
  logic [TO_W-1:0]       to_cnt;

  // Idle PS/2 lines are high; resetting the sync chain high avoids a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_q    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_q    <= clk_sync[1];
    end
  end

  assign fall      = clk_q & ~clk_sync[1];
  assign frame_nxt = {dat_sync[1], shreg[FRAME_BITS-1:1]};
  assign timeout   = (state == RX_SHIFT) && !fall && (to_cnt == TO_W'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (fall) state_nxt = RX_SHIFT;
      RX_SHIFT: if ((fall && bit_cnt == 4'd10) || timeout) state_nxt = RX_IDLE;
      default:  state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
      to_cnt  <= '0;
      rx_byte <= '0;
      rx_vld  <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      rx_vld <= 1'b0;
      rx_err <= 1'b0;
      if (fall || state == RX_IDLE || timeout) to_cnt <= '0;
      else                                     to_cnt <= to_cnt + 1'b1;
      if (fall) shreg <= frame_nxt;
      case (state)
        RX_IDLE: if (fall) bit_cnt <= 4'd1;
        RX_SHIFT: begin
          if (fall) begin
            if (bit_cnt == 4'd10) begin
              bit_cnt <= '0;
              rx_byte <= frame_nxt[8:1];
              rx_vld  <= frame_ok(frame_nxt);
              rx_err  <= !frame_ok(frame_nxt);
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else if (timeout) begin
            bit_cnt <= '0;
            rx_err  <= 1'b1;
          end
        end
        default: bit_cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/xps2_host_bridge.sv
// PS/2 keyboard to register-file mailbox bridge: decodes prefixes, queues key
// words and delivers each one through a KEY word plus FLAG handshake.
module xps2_host_bridge
  import xps2_host_bridge_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REGF_ADDR_W = 4,
  parameter int KEY_ADDR    = 0,
  parameter int FLAG_ADDR   = 1,
  parameter int TIMEOUT_CYC = 5000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  output logic [REGF_ADDR_W-1:0] par_addr,
  output logic                   par_we,
  output logic [DATA_W-1:0]      par_wdata,
  input  logic [DATA_W-1:0]      par_rdata,
  output logic                   frame_err,
  output logic                   fifo_ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [REGF_ADDR_W-1:0] KEY_A  = REGF_ADDR_W'(KEY_ADDR);
  localparam logic [REGF_ADDR_W-1:0] FLAG_A = REGF_ADDR_W'(FLAG_ADDR);

  logic [7:0]  rx_byte;
  logic        rx_vld, rx_err;
  logic        ext, brk;
  logic        push_req, push_ok, pop;
  key_word_t   push_word;
  logic [KEY_W-1:0] head;
  key_word_t   mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  host_state_t h_state, h_nxt;
  logic        rdata_unused;

  xps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .rx_vld   (rx_vld),
    .rx_err   (rx_err)
  );

  assign frame_err    = rx_err;
  assign rdata_unused = ^par_rdata[DATA_W-1:1];

  // Prefix bytes only arm ext/brk; any other valid byte becomes a key word.
  assign push_req  = rx_vld && rx_byte != PS2_EXT_CODE && rx_byte != PS2_BRK_CODE;
  assign push_word = '{ext: ext, brk: brk, code: rx_byte};

  always_ff @(posedge clk) begin
    if (rst || rx_err) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (rx_vld) begin
      if (rx_byte == PS2_EXT_CODE) ext <= 1'b1;
      else if (rx_byte == PS2_BRK_CODE) brk <= 1'b1;
      else begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop        = (h_state == H_WRFLAG);
  // The head was already written out during H_WRKEY, so a full-FIFO push may reuse its slot.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign head       = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_ovf <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_req && !push_ok) fifo_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) h_state <= H_IDLE;
    else     h_state <= h_nxt;
  end

  // POLL0 presents the FLAG address; POLL1 holds it so a registered read has landed.
  always_comb begin
    h_nxt     = h_state;
    par_addr  = '0;
    par_we    = 1'b0;
    par_wdata = '0;
    case (h_state)
      H_IDLE:  if (!fifo_empty) h_nxt = H_POLL0;
      H_POLL0: begin
        par_addr = FLAG_A;
        h_nxt    = H_POLL1;
      end
      H_POLL1: begin
        par_addr = FLAG_A;
        h_nxt    = par_rdata[0] ? H_POLL0 : H_WRKEY;
      end
      H_WRKEY: begin
        par_addr  = KEY_A;
        par_we    = 1'b1;
        par_wdata = {{(DATA_W-KEY_W){1'b0}}, head};
        h_nxt     = H_WRFLAG;
      end
      H_WRFLAG: begin
        par_addr  = FLAG_A;
        par_we    = 1'b1;
        par_wdata = DATA_W'(1);
        h_nxt     = H_IDLE;
      end
      default: h_nxt = H_IDLE;
    endcase
  end

endmodule

// File: tb/tb_xps2_host_bridge.sv
// Self-checking bench: PS/2 frame driver, register-file mailbox model with an
// auto-consuming controller, and a byte-level decode reference model.
module tb_xps2_host_bridge;

  localparam int DATA_W      = 32;
  localparam int REGF_ADDR_W = 4;
  localparam int KEY_ADDR    = 0;
  localparam int FLAG_ADDR   = 1;
  localparam int TIMEOUT_CYC = 5000;
  localparam int HALF        = 8;
  localparam int GAP         = 30;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   ps2_clk = 1'b1;
  logic                   ps2_data = 1'b1;
  logic [REGF_ADDR_W-1:0] par_addr;
  logic                   par_we;
  logic [DATA_W-1:0]      par_wdata;
  logic [DATA_W-1:0]      par_rdata = '0;
  logic                   frame_err;
  logic                   fifo_ovf;

  int n_chk = 0;
  int n_pass = 0;

  xps2_host_bridge #(
    .DATA_W(DATA_W), .REGF_ADDR_W(REGF_ADDR_W), .KEY_ADDR(KEY_ADDR),
    .FLAG_ADDR(FLAG_ADDR), .TIMEOUT_CYC(TIMEOUT_CYC), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .par_addr(par_addr), .par_we(par_we), .par_wdata(par_wdata),
    .par_rdata(par_rdata), .frame_err(frame_err), .fifo_ovf(fifo_ovf)
  );

  always #5 clk = ~clk;

  // Register-file model with registered read; controller clears FLAG a few cycles after it is set.
  logic        flag = 1'b0;
  logic [31:0] key_reg = '0;
  logic        hold_flag = 1'b0;
  int          clr_cnt = 0;

  always @(posedge clk) begin
    par_rdata <= (par_addr == REGF_ADDR_W'(FLAG_ADDR)) ? {31'b0, flag} : key_reg;
    if (par_we) begin
      if (par_addr == REGF_ADDR_W'(FLAG_ADDR)) flag <= par_wdata[0];
      if (par_addr == REGF_ADDR_W'(KEY_ADDR))  key_reg <= par_wdata;
      clr_cnt <= 0;
    end else if (flag) begin
      if (clr_cnt == 3) begin
        flag    <= 1'b0;
        clr_cnt <= 0;
      end else begin
        clr_cnt <= clr_cnt + 1;
      end
    end
    if (hold_flag) flag <= 1'b1;
  end

  // Monitor, sampled on the falling clock edge.
  logic [31:0] key_log[$];
  int flag_wr = 0, poll_cnt = 0, err_cnt = 0, contract_viol = 0;

  always @(negedge clk) begin
    if (par_we && par_addr == REGF_ADDR_W'(KEY_ADDR)) begin
      key_log.push_back(par_wdata);
      if (flag !== 1'b0) contract_viol <= contract_viol + 1;
    end
    if (par_we && par_addr == REGF_ADDR_W'(FLAG_ADDR) && par_wdata == 32'd1) flag_wr <= flag_wr + 1;
    if (!par_we && par_addr == REGF_ADDR_W'(FLAG_ADDR)) poll_cnt <= poll_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  // Reference model: decode rules applied per received byte.
  logic        m_ext = 1'b0, m_brk = 1'b0;
  logic [31:0] exp_q[$];
  int          exp_err = 0;

  task automatic model_rx(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      exp_q.push_back(32'(b) + (m_brk ? 32'h100 : 32'h0) + (m_ext ? 32'h200 : 32'h0));
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (GAP) @(posedge clk);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_chk++; if (par_addr !== '0) $display("FAIL reset_addr got %0h want 0", par_addr); else n_pass++;
    n_chk++; if (par_we !== 1'b0) $display("FAIL reset_we got %0b want 0", par_we); else n_pass++;
    n_chk++; if (par_wdata !== '0) $display("FAIL reset_wdata got %0h want 0", par_wdata); else n_pass++;
    n_chk++; if (frame_err !== 1'b0) $display("FAIL reset_ferr got %0b want 0", frame_err); else n_pass++;
    n_chk++; if (fifo_ovf !== 1'b0) $display("FAIL reset_ovf got %0b want 0", fifo_ovf); else n_pass++;
    rst = 1'b0;
    settle(5);
  endtask

  task automatic test_make;
    int k0, f0, e0;
    k0 = key_log.size(); f0 = flag_wr; e0 = err_cnt;
    send_frame(8'h1C, 0);
    settle(60);
    n_chk++; if (key_log.size() - k0 !== 1) $display("FAIL make_count got %0d want 1", key_log.size() - k0); else n_pass++;
    if (key_log.size() > k0) begin
      n_chk++; if (key_log[k0] !== 32'h1C) $display("FAIL make_key got %0h want 1c", key_log[k0]); else n_pass++;
    end
    n_chk++; if (flag_wr - f0 !== 1) $display("FAIL make_flagwr got %0d want 1", flag_wr - f0); else n_pass++;
    n_chk++; if (err_cnt - e0 !== 0) $display("FAIL make_ferr got %0d want 0", err_cnt - e0); else n_pass++;
  endtask

  task automatic test_ext_brk;
    int k0;
    k0 = key_log.size();
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    n_chk++; if (key_log.size() - k0 !== 0) $display("FAIL prefix_nowrite got %0d want 0", key_log.size() - k0); else n_pass++;
    send_frame(8'h75, 0);
    settle(60);
    n_chk++; if (key_log.size() - k0 !== 1) $display("FAIL extbrk_count got %0d want 1", key_log.size() - k0); else n_pass++;
    if (key_log.size() > k0) begin
      n_chk++; if (key_log[k0] !== 32'h375) $display("FAIL extbrk_key got %0h want 375", key_log[k0]); else n_pass++;
    end
  endtask

  task automatic test_bad_parity;
    int k0, e0;
    k0 = key_log.size(); e0 = err_cnt;
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 1);
    settle(40);
    n_chk++; if (err_cnt - e0 !== 1) $display("FAIL parity_ferr got %0d want 1", err_cnt - e0); else n_pass++;
    n_chk++; if (key_log.size() - k0 !== 0) $display("FAIL parity_nowrite got %0d want 0", key_log.size() - k0); else n_pass++;
    send_frame(8'h32, 0);
    settle(60);
    n_chk++; if (key_log.size() - k0 !== 1) $display("FAIL parity_next_count got %0d want 1", key_log.size() - k0); else n_pass++;
    if (key_log.size() > k0) begin
      n_chk++; if (key_log[k0] !== 32'h32) $display("FAIL parity_next_key got %0h want 32", key_log[k0]); else n_pass++;
    end
  endtask

  task automatic test_timeout;
    int k0, e0;
    k0 = key_log.size(); e0 = err_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
    settle(TIMEOUT_CYC + 10);
    n_chk++; if (err_cnt - e0 !== 1) $display("FAIL timeout_ferr got %0d want 1", err_cnt - e0); else n_pass++;
    n_chk++; if (key_log.size() - k0 !== 0) $display("FAIL timeout_nowrite got %0d want 0", key_log.size() - k0); else n_pass++;
    send_frame(8'h16, 0);
    settle(60);
    n_chk++; if (key_log.size() - k0 !== 1) $display("FAIL timeout_next_count got %0d want 1", key_log.size() - k0); else n_pass++;
    if (key_log.size() > k0) begin
      n_chk++; if (key_log[k0] !== 32'h16) $display("FAIL timeout_next_key got %0h want 16", key_log[k0]); else n_pass++;
    end
  endtask

  task automatic test_overflow;
    int k0, p0;
    logic [7:0] codes[5];
    hold_flag = 1'b1;
    settle(5);
    k0 = key_log.size(); p0 = poll_cnt;
    for (int i = 0; i < 5; i++) begin
      codes[i] = 8'h10 + 8'(i * 7);
      send_frame(codes[i], 0);
    end
    settle(40);
    n_chk++; if (key_log.size() - k0 !== 0) $display("FAIL ovf_nowrite got %0d want 0", key_log.size() - k0); else n_pass++;
    n_chk++; if (fifo_ovf !== 1'b1) $display("FAIL ovf_flag got %0b want 1", fifo_ovf); else n_pass++;
    n_chk++; if (poll_cnt - p0 <= 0) $display("FAIL ovf_polls got %0d want >0", poll_cnt - p0); else n_pass++;
    hold_flag = 1'b0;
    settle(250);
    n_chk++; if (key_log.size() - k0 !== 4) $display("FAIL ovf_drain_count got %0d want 4", key_log.size() - k0); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (key_log.size() > k0 + i) begin
        n_chk++;
        if (key_log[k0 + i] !== 32'(codes[i])) $display("FAIL ovf_order[%0d] got %0h want %0h", i, key_log[k0 + i], codes[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_write;
    int k0;
    bit seen;
    hold_flag = 1'b1;
    settle(5);
    for (int i = 0; i < 3; i++) send_frame(8'h40 + 8'(i), 0);
    hold_flag = 1'b0;
    seen = 0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk);
      if (par_we && par_addr == REGF_ADDR_W'(KEY_ADDR)) seen = 1;
    end
    n_chk++; if (!seen) $display("FAIL rstmid_wrkey_seen got 0 want 1"); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (par_we !== 1'b0) $display("FAIL rstmid_we got %0b want 0", par_we); else n_pass++;
    n_chk++; if (par_addr !== '0) $display("FAIL rstmid_addr got %0h want 0", par_addr); else n_pass++;
    n_chk++; if (fifo_ovf !== 1'b0) $display("FAIL rstmid_ovf got %0b want 0", fifo_ovf); else n_pass++;
    rst = 1'b0;
    k0 = key_log.size();
    settle(300);
    n_chk++; if (key_log.size() - k0 !== 0) $display("FAIL rstmid_fifo_empty got %0d writes want 0", key_log.size() - k0); else n_pass++;
  endtask

  task automatic test_random;
    int k0, e0, n;
    logic [7:0] b;
    bit bad;
    k0 = key_log.size(); e0 = err_cnt;
    exp_q.delete(); exp_err = 0; m_ext = 1'b0; m_brk = 1'b0;
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 9))
        0:       begin b = 8'hE0; bad = 0; end
        1:       begin b = 8'hF0; bad = 0; end
        2:       begin b = 8'($urandom); bad = 1; end
        default: begin b = 8'($urandom); bad = 0; end
      endcase
      send_frame(b, bad);
      model_rx(b, !bad);
      settle(40);
    end
    settle(60);
    n = key_log.size() - k0;
    n_chk++; if (n !== exp_q.size()) $display("FAIL rand_count got %0d want %0d", n, exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      n_chk++;
      if (key_log[k0 + i] !== exp_q[i]) $display("FAIL rand_key[%0d] got %0h want %0h", i, key_log[k0 + i], exp_q[i]);
      else n_pass++;
    end
    n_chk++; if (err_cnt - e0 !== exp_err) $display("FAIL rand_ferr got %0d want %0d", err_cnt - e0, exp_err); else n_pass++;
    n_chk++; if (contract_viol !== 0) $display("FAIL key_while_flag got %0d want 0", contract_viol); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_make();
    test_ext_brk();
    test_bad_parity();
    test_timeout();
    test_overflow();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
